// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//   Receive controller for the UART interface. The asynchronous RX pin is
//   brought into the clk domain through a two-flop synchroniser. A small FSM
//   then samples the start bit at half a bit period, the data bits (LSB first)
//   and the stop bit at the middle of each bit. Each complete byte is handed
//   over through a one-entry valid/ready buffer. Framing errors and overruns
//   are reported as single-cycle pulses.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit period (>= 4)
//   DATA_BITS     data bits per frame, LSB first (5..9)
//
// Ports
//   clk          in   clock, all flops on posedge
//   rst_n        in   asynchronous active-low reset
//   rx_i         in   raw RX pin, asynchronous to clk, idles high
//   data_o       out  received byte, stable while valid_o=1
//   valid_o      out  data_o holds an unconsumed byte
//   ready_i      in   consumer takes data_o when valid_o && ready_i
//   frame_err_o  out  1-cycle pulse: stop bit sampled low
//   overrun_o    out  1-cycle pulse: frame completed while buffer full
//   busy_o       out  FSM not in IDLE
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BIDX_W = $clog2(DATA_BITS + 1);

  // Start bit is re-checked at its middle; data and stop bits one full period later.
  localparam logic [CNT_W-1:0]  HALF_C     = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  LAST_C     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [BIDX_W-1:0] BIDX_ZERO  = {BIDX_W{1'b0}};
  localparam logic [BIDX_W-1:0] BIDX_ONE   = BIDX_W'(1);
  localparam logic [BIDX_W-1:0] BIDX_LAST  = BIDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  logic [1:0]           sync_r;
  logic                 rx_s;
  state_t               state_r;
  state_t               state_nxt_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic [BIDX_W-1:0]    bidx_r;
  logic [BIDX_W-1:0]    bidx_nxt_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_nxt_s;
  logic                 frame_done_s;
  logic                 frame_err_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx_i};
    end
  end

  assign rx_s = sync_r[1];

  // FSM state, bit-period counter, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      bidx_r  <= BIDX_ZERO;
      shift_r <= {DATA_BITS{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      bidx_r  <= bidx_nxt_s;
      shift_r <= shift_nxt_s;
    end
  end

  // Next-state logic; the counter is cleared on every state change.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r + CNT_ONE;
    bidx_nxt_s   = bidx_r;
    shift_nxt_s  = shift_r;
    frame_done_s = 1'b0;
    frame_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        if (!rx_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == HALF_C) begin
          cnt_nxt_s = CNT_ZERO;
          if (!rx_s) begin
            state_nxt_s = ST_DATA;
            bidx_nxt_s  = BIDX_ZERO;
          end else begin
            // Line went back high before mid start bit: treat as glitch.
            state_nxt_s = ST_IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_r == LAST_C) begin
          cnt_nxt_s   = CNT_ZERO;
          shift_nxt_s = {rx_s, shift_r[DATA_BITS-1:1]};
          bidx_nxt_s  = bidx_r + BIDX_ONE;
          if (bidx_r == BIDX_LAST) begin
            state_nxt_s = ST_STOP;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt_r == LAST_C) begin
          cnt_nxt_s = CNT_ZERO;
          if (rx_s) begin
            // Return at mid stop bit so a back-to-back start edge is not missed.
            frame_done_s = 1'b1;
            state_nxt_s  = ST_IDLE;
          end else begin
            frame_err_s = 1'b1;
            state_nxt_s = ST_WAIT_IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_WAIT_IDLE: begin
        // Hold here through a break condition until the line is released.
        cnt_nxt_s = CNT_ZERO;
        if (rx_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
        bidx_nxt_s  = BIDX_ZERO;
      end
    endcase
  end

  // One-entry output buffer and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o      <= {DATA_BITS{1'b0}};
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= frame_err_s;
      overrun_o   <= 1'b0;
      if (frame_done_s) begin
        if (!valid_o || ready_i) begin
          data_o  <= shift_r;
          valid_o <= 1'b1;
        end else begin
          // Buffer still full: keep the old byte, drop the new one.
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end else begin
        valid_o <= valid_o;
      end
    end
  end

  assign busy_o = (state_r != ST_IDLE);

endmodule
